// File: rtl/audio_stream_bridge.sv
// audio_stream_bridge: one circular FIFO per audio channel, filled from
// valid/ready sample streams and drained by the CPU over a small register bus.
// Provides status/control registers, a watermark interrupt, per-channel flush
// and sticky underrun flags.
// Build option: define DROP_COUNT_EN to add 16-bit saturating drop counters
// readable (and clearable by any write) at register index 3.
module audio_stream_bridge #(
   parameter int DATA_SIZE  = 28,
   parameter int NUM_CH     = 2,
   parameter int DEPTH      = 2048,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        chipselect,
   input  logic [2:0]                  address,
   input  logic                        read,
   input  logic                        write,
   input  logic [31:0]                 write_data,
   output logic [31:0]                 read_data,
   input  logic [NUM_CH-1:0]           source_valid,
   input  logic [NUM_CH*DATA_SIZE-1:0] source_data,
   output logic [NUM_CH-1:0]           source_ready,
   output logic                        irq
);

   localparam int               CNT_W   = ADDR_WIDTH + 1;
   localparam int               OCC_CH  = (NUM_CH < 2) ? NUM_CH : 2;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   localparam logic [2:0] REG_DROP      = 3'd3;
   localparam logic [2:0] REG_STATUS    = 3'd4;
   localparam logic [2:0] REG_WATERMARK = 3'd5;
   localparam logic [2:0] REG_CONTROL   = 3'd6;
   localparam logic [2:0] REG_OCCUPANCY = 3'd7;

   logic [DATA_SIZE-1:0]  mem    [NUM_CH][DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr [NUM_CH];
   logic [ADDR_WIDTH-1:0] rd_ptr [NUM_CH];
   logic [CNT_W-1:0]      cnt    [NUM_CH];

   logic [CNT_W-1:0]  watermark;
   logic              irq_en;
   logic [NUM_CH-1:0] underrun;
   logic [NUM_CH-1:0] above;

   logic              rd_en, wr_en;
   logic [NUM_CH-1:0] full, empty, push, pop, flush, above_next;
   logic [31:0]       status, rdata_next;

`ifdef DROP_COUNT_EN
   logic [15:0] drop [NUM_CH];
`endif

   // Per-channel handshake, pop, flush and watermark-compare decode.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rd_en      = chipselect && read && !write;
      wr_en      = chipselect && write;
      full       = '0;
      empty      = '0;
      push       = '0;
      pop        = '0;
      flush      = '0;
      above_next = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         full[c]       = (cnt[c] == DEPTH_C);
         empty[c]      = (cnt[c] == '0);
         push[c]       = source_valid[c] && !full[c];
         pop[c]        = rd_en && (address == 3'(c)) && !empty[c];
         flush[c]      = wr_en && (address == REG_CONTROL) && write_data[8+c];
         above_next[c] = (cnt[c] >= watermark);
      end
   end

   assign source_ready = ~full;

   // Read-data mux: pop data, registers, or zero for unused indices.
   always_comb begin
      status     = '0;
      rdata_next = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         status[c]    = empty[c];
         status[8+c]  = full[c];
         status[16+c] = above[c];
         status[24+c] = underrun[c];
      end
      case (address)
         REG_STATUS:    rdata_next = status;
         REG_WATERMARK: rdata_next = 32'(watermark);
         REG_CONTROL:   rdata_next = {31'd0, irq_en};
         REG_OCCUPANCY: begin
            for (int c = 0; c < OCC_CH; c++) rdata_next[c*16 +: 16] = 16'(cnt[c]);
         end
         default: begin
            for (int c = 0; c < NUM_CH; c++) begin
               if ((address == 3'(c)) && !empty[c]) rdata_next = 32'(mem[c][rd_ptr[c]]);
            end
`ifdef DROP_COUNT_EN
            if ((address == REG_DROP) && (NUM_CH < 4)) begin
               for (int c = 0; c < OCC_CH; c++) rdata_next[c*16 +: 16] = drop[c];
            end
`endif
         end
      endcase
   end

   // Sample storage written on each accepted push.
   // NOTE: the storage array has no reset; pointers and counts alone define validity.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (push[c]) mem[c][wr_ptr[c]] <= source_data[c*DATA_SIZE +: DATA_SIZE];
      end
   end

   // FIFO pointers/counts, flags, bus registers and the interrupt.
   // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            cnt[c]    <= '0;
         end
         watermark <= CNT_W'(DEPTH / 2);
         irq_en    <= 1'b0;
         underrun  <= '0;
         above     <= '0;
         irq       <= 1'b0;
         read_data <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (flush[c]) begin
               wr_ptr[c] <= '0;
               rd_ptr[c] <= '0;
               cnt[c]    <= '0;
            end else begin
               if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
               if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
               if (push[c] && !pop[c])      cnt[c] <= cnt[c] + 1'b1;
               else if (pop[c] && !push[c]) cnt[c] <= cnt[c] - 1'b1;
            end
            if (rd_en && (address == 3'(c)) && empty[c])
               underrun[c] <= 1'b1;
            else if (wr_en && (address == REG_STATUS) && write_data[24+c])
               underrun[c] <= 1'b0;
         end
         above <= above_next;
         irq   <= irq_en && (|above_next);
         if (rd_en) read_data <= rdata_next;
         if (wr_en && (address == REG_WATERMARK))
            watermark <= (write_data > 32'(DEPTH)) ? DEPTH_C : write_data[CNT_W-1:0];
         if (wr_en && (address == REG_CONTROL))
            irq_en <= write_data[0];
      end
   end

`ifdef DROP_COUNT_EN
   // Count samples offered while the channel is full, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) drop[c] <= '0;
      end else if (wr_en && (address == REG_DROP)) begin
         for (int c = 0; c < NUM_CH; c++) drop[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (source_valid[c] && full[c] && (drop[c] != 16'hFFFF)) drop[c] <= drop[c] + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_audio_stream_bridge.sv
// Directed self-checking bench for audio_stream_bridge (default parameters).
module tb_audio_stream_bridge;

   localparam int DATA_SIZE = 28;
   localparam int NUM_CH    = 2;
   localparam int DEPTH     = 2048;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic                        chipselect = 1'b0;
   logic [2:0]                  address = '0;
   logic                        read = 1'b0;
   logic                        write = 1'b0;
   logic [31:0]                 write_data = '0;
   logic [31:0]                 read_data;
   logic [NUM_CH-1:0]           source_valid = '0;
   logic [NUM_CH*DATA_SIZE-1:0] source_data = '0;
   logic [NUM_CH-1:0]           source_ready;
   logic                        irq;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] rd;

   always #10 clk = ~clk;

   audio_stream_bridge #(
      .DATA_SIZE(DATA_SIZE),
      .NUM_CH   (NUM_CH),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .chipselect  (chipselect),
      .address     (address),
      .read        (read),
      .write       (write),
      .write_data  (write_data),
      .read_data   (read_data),
      .source_valid(source_valid),
      .source_data (source_data),
      .source_ready(source_ready),
      .irq         (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One-cycle bus read, issued and sampled on falling edges.
   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      d = read_data;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
      chipselect = 1'b1; write = 1'b1; address = a; write_data = v;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0; write_data = '0;
   endtask

   // Back-to-back stream words base, base+1, ... on one channel.
   task automatic push_burst(input int ch, input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         source_valid[ch] = 1'b1;
         source_data[ch*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(base + 32'(i));
         @(negedge clk);
      end
      source_valid[ch] = 1'b0;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check("rst_ready", 32'(source_ready), 32'h3);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_read_data", read_data, 32'h0);
      bus_read(3'd4, rd); check("rst_status", rd, 32'h0000_0003);
      bus_read(3'd5, rd); check("rst_watermark", rd, 32'h0000_0400);
      bus_read(3'd6, rd); check("rst_control", rd, 32'h0);
      bus_read(3'd7, rd); check("rst_occupancy", rd, 32'h0);

      // FIFO order on ch0
      push_burst(0, 5, 32'h1);
      for (int i = 1; i <= 5; i++) begin
         bus_read(3'd0, rd); check("ch0_pop", rd, 32'(i));
      end
      @(negedge clk);
      check("read_data_hold", read_data, 32'h5);
      bus_read(3'd4, rd); check("ch0_empty_status", rd, 32'h0000_0003);

      // Fill ch1, drop one extra word, drain and check the wrap
      push_burst(1, DEPTH, 32'h0);
      check("ch1_full_ready", 32'(source_ready), 32'h1);
      source_valid[1] = 1'b1;
      source_data[DATA_SIZE +: DATA_SIZE] = 28'hABCDEF;
      @(negedge clk);
      source_valid[1] = 1'b0;
      bus_read(3'd4, rd); check("ch1_full_status", rd, 32'h0002_0201);
      bus_read(3'd7, rd); check("ch1_full_occupancy", rd, 32'h0800_0000);
      for (int i = 0; i < DEPTH; i++) begin
         bus_read(3'd1, rd); check("ch1_pop", rd, 32'(i));
      end
      check("ch1_drained_ready", 32'(source_ready), 32'h3);
      bus_read(3'd4, rd); check("ch1_drained_status", rd, 32'h0000_0003);

      // Watermark interrupt
      bus_write(3'd5, 32'h0000_FFFF);
      bus_read(3'd5, rd); check("watermark_clamp", rd, 32'h0000_0800);
      bus_write(3'd5, 32'h4);
      bus_write(3'd6, 32'h1);
      bus_read(3'd5, rd); check("watermark_rw", rd, 32'h4);
      bus_read(3'd6, rd); check("control_rw", rd, 32'h1);
      push_burst(0, 4, 32'h10);
      check("irq_not_yet", 32'(irq), 32'h0);
      @(negedge clk);
      check("irq_set", 32'(irq), 32'h1);
      bus_read(3'd4, rd); check("above_status", rd, 32'h0001_0002);
      bus_read(3'd0, rd); check("wm_pop", rd, 32'h10);
      check("irq_still_set", 32'(irq), 32'h1);
      @(negedge clk);
      check("irq_clear", 32'(irq), 32'h0);

      // Underrun on empty ch1 and W1C clear; unused indices
      bus_read(3'd1, rd); check("underrun_data", rd, 32'h0);
      bus_read(3'd4, rd); check("underrun_status", rd, 32'h0200_0002);
      bus_write(3'd4, 32'h0200_0000);
      bus_read(3'd4, rd); check("underrun_cleared", rd, 32'h0000_0002);
      bus_read(3'd2, rd); check("unused_addr2", rd, 32'h0);
      bus_read(3'd3, rd);
`ifdef DROP_COUNT_EN
      check("drop_after_fill", rd, 32'h0001_0000);
`else
      check("unused_addr3", rd, 32'h0);
`endif
      bus_write(3'd3, 32'hFFFF_FFFF);

      // Simultaneous push/pop, then flush with concurrent push
      bus_read(3'd7, rd); check("occ_before", rd, 32'h3);
      source_valid[0] = 1'b1; source_data[0 +: DATA_SIZE] = 28'h20;
      chipselect = 1'b1; read = 1'b1; address = 3'd0;
      @(negedge clk);
      source_valid[0] = 1'b0; chipselect = 1'b0; read = 1'b0;
      check("pushpop_data", read_data, 32'h11);
      bus_read(3'd7, rd); check("occ_pushpop", rd, 32'h3);
      source_valid[0] = 1'b1; source_data[0 +: DATA_SIZE] = 28'h21;
      chipselect = 1'b1; write = 1'b1; address = 3'd6; write_data = 32'h100;
      @(negedge clk);
      source_valid[0] = 1'b0; chipselect = 1'b0; write = 1'b0; write_data = '0;
      bus_read(3'd7, rd); check("occ_flush", rd, 32'h0);
      bus_read(3'd6, rd); check("flush_reads_zero", rd, 32'h0);
      push_burst(0, 1, 32'h33);
      bus_read(3'd0, rd); check("post_flush_pop", rd, 32'h33);

      // Reset mid-operation with stream writes in the reset cycle
      bus_write(3'd6, 32'h1);
      push_burst(1, 10, 32'h100);
      push_burst(0, 2, 32'h200);
      check("pre_reset_irq", 32'(irq), 32'h1);
      bus_read(3'd1, rd); check("pre_reset_pop", rd, 32'h100);
      rst = 1'b0;
      source_valid = 2'b11;
      source_data = {28'h0AA, 28'h0BB};
      @(negedge clk);
      rst = 1'b1;
      source_valid = 2'b00;
      check("mid_rst_ready", 32'(source_ready), 32'h3);
      check("mid_rst_irq", 32'(irq), 32'h0);
      check("mid_rst_read_data", read_data, 32'h0);
      bus_read(3'd7, rd); check("mid_rst_occupancy", rd, 32'h0);
      bus_read(3'd4, rd); check("mid_rst_status", rd, 32'h0000_0003);
      bus_read(3'd5, rd); check("mid_rst_watermark", rd, 32'h0000_0400);
      bus_read(3'd6, rd); check("mid_rst_control", rd, 32'h0);
      bus_read(3'd3, rd); check("mid_rst_addr3", rd, 32'h0);
      push_burst(1, 1, 32'h55);
      bus_read(3'd1, rd); check("post_rst_pop", rd, 32'h55);

`ifdef DROP_COUNT_EN
      // Drop counter: three valid cycles while ch0 is full
      push_burst(0, DEPTH, 32'h0);
      source_valid[0] = 1'b1;
      repeat (3) @(negedge clk);
      source_valid[0] = 1'b0;
      bus_read(3'd3, rd); check("drop_count", rd, 32'h0000_0003);
      bus_write(3'd3, 32'h0);
      bus_read(3'd3, rd); check("drop_cleared", rd, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_stream_bridge.md
Name: audio_stream_bridge

Overview:
Multi-channel successor to the single-stream FIFO bridge. It has one circular FIFO per audio channel, fed from per-channel valid/ready streams and drained by the processor over a small register bus. It adds a working watermark interrupt, status and control registers, per-channel flush, and underrun flags. It sits between the audio sample pipeline and the Avalon-style CPU slave.

Parameters:
DATA_SIZE, 28, sample width in bits (1..32)
NUM_CH, 2, number of channels (1..4)
DEPTH, 2048, words per channel FIFO (power of two, >=4)
ADDR_WIDTH, $clog2(DEPTH), FIFO pointer width (derived)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset: one clock; reset is synchronous and active-low
chipselect  in  1  bus select
address  in  3  register index
read  in  1  bus read strobe
write  in  1  bus write strobe
write_data  in  32  bus write data
read_data  out  32  registered read data
source_valid  in  NUM_CH  per-channel valid
source_data  in  NUM_CH*DATA_SIZE  channel c in bits [c*DATA_SIZE +: DATA_SIZE]
source_ready  out  NUM_CH  per-channel ready
irq  out  1  level watermark interrupt

Behaviour:
- Reset (rst==0 at a clk edge):
  - All pointers and counts = 0.
  - read_data = 0, irq = 0, source_ready = all 1.
  - watermark = DEPTH/2, irq_en = 0, underrun flags = 0.
  - FIFO memory contents are not cleared.
- Each channel FIFO: wr_ptr and rd_ptr both increment and wrap modulo DEPTH. cnt is ADDR_WIDTH+1 bits, range 0..DEPTH.
- full[c] = (cnt==DEPTH); empty[c] = (cnt==0).
- source_ready[c] = !full[c], combinational from registered cnt.
- Push: source_valid[c] && source_ready[c] stores data at wr_ptr and increments cnt. Valid while full is ignored; the data is dropped and nothing else changes.
- Bus read, 1-cycle latency: read_data updates on the edge where chipselect && read is sampled, and holds until the next read.
- Register map:
  - 0..NUM_CH-1: pop channel. Returns zero-extended mem[rd_ptr], increments rd_ptr, decrements cnt. If the channel is empty: returns 0, pointers unchanged, sets underrun[c].
  - Indices >= NUM_CH that are below 4: read 0, no side effect.
  - 4 STATUS (RO except W1C): [3:0] empty, [11:8] full, [19:16] above-watermark, [27:24] underrun sticky. Unused bits read 0. Writing 1 to bit 24+c clears underrun[c].
  - 5 WATERMARK (RW): [ADDR_WIDTH:0]. Writes are clamped to DEPTH.
  - 6 CONTROL (RW): bit0 irq_en. Bits [11:8] flush, which are self-clearing and read 0.
  - 7 OCCUPANCY (RO): cnt of channel write_data-selected? No: returns cnt[0] in [15:0] and cnt[1] in [31:16]. Channels 2 and 3 are not visible.
- Simultaneous push and pop on one channel: both take effect and cnt is unchanged. This is legal even when full; the pop frees a slot but ready stays low that cycle.
- Flush[c]: wr_ptr = rd_ptr = cnt = 0 on the next edge. Flush wins over a same-cycle push or pop on that channel. The underrun flag is unaffected.
- above[c] = (cnt[c] >= watermark), registered.
- irq = irq_en && |above, registered, so it is 1 cycle after the count crosses the watermark. irq deasserts when the condition falls.
- Simultaneous bus read and write are illegal; write takes priority and read_data holds.
- Reset mid-operation discards all FIFO data. Stream writes presented in the reset cycle are ignored.

Optional Feature:
DROP_COUNT_EN. When defined:
- Each channel has a 16-bit saturating counter that increments when source_valid[c] is high while full[c].
- Reading address 3 returns {drop[1], drop[0]}.
- Writing any value to address 3 clears all counters.
- Reset clears all counters.

When not defined:
- No counters are built.
- Address 3 behaves as the other unused indices: reads 0, writes ignored.

Test Plan:
- Reset, push 0x0000001..0x0000005 on ch0, read address 0 five times -> read_data 1,2,3,4,5 in FIFO order, one cycle after each read. Then STATUS[0] = 1.
- Push DEPTH words to ch1 -> source_ready[1] = 0 and STATUS[9] = 1. One further valid word is dropped. Pop the full FIFO -> the last value returned is word DEPTH-1, confirming the wrap is correct.
- WATERMARK = 4, CONTROL = 1, push 4 words on ch0 -> irq = 1 one cycle after cnt reaches 4. One pop -> irq = 0 one cycle later.
- Read address 1 on empty ch1 -> read_data = 0 and STATUS[25] = 1. Write 0x02000000 to STATUS -> bit 25 clears.
- With ch0 holding 3 words, push and pop in the same cycle, then flush ch0 with a concurrent push -> OCCUPANCY[15:0] goes 3 -> 3 -> 0.
- Assert rst=0 for one cycle with 10 words queued -> all counts 0, irq = 0, source_ready = all 1, read_data = 0. With DROP_COUNT_EN defined, 3 valid cycles while full -> address 3 reads 3.
